cbus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single outgoing cache bus (cbus) among the instruction cache, data cache and any further cbus masters. It sits between the cache refill/writeback ports and the top-level `creq`/`cresp` pair. It grants one requester at a time and holds that grant for the whole burst, until the downstream bus returns `last`. It then rotates priority so that no master starves.

---
 rtl/cbus_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter for the shared cache bus. It holds each grant for a full burst.
// Define CBUS_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority (index 0 wins).

package cbus_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 64;
  localparam int unsigned CBUS_LEN_W  = 8;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [2:0]               size;
    logic [CBUS_LEN_W-1:0]    len;
    logic [CBUS_ADDR_W-1:0]   addr;
    logic [CBUS_DATA_W-1:0]   data;
    logic [CBUS_DATA_W/8-1:0] strobe;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic             found;
  logic             burst_done;

  assign burst_done = (state == BUSY) && oresp.ready && oresp.last;

  // First valid master at or after ptr, wrapping at NUM_INPUTS
  always_comb begin
    logic [SEL_W:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
        cand = cand - (SEL_W+1)'(NUM_INPUTS);
      end
      if (!found && ireqs[cand[SEL_W-1:0]].valid) begin
        found  = 1'b1;
        winner = cand[SEL_W-1:0];
      end
    end
  end

  // Grant FSM: latch winner in IDLE, hold until the downstream burst ends
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (burst_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q;

  // Rotate priority past the master that just finished
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (burst_done) begin
      ptr_q <= (sel == SEL_W'(NUM_INPUTS - 1)) ? '0 : sel + SEL_W'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Pass-through routing of the granted master; everything else idles at zero
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      oreq = ireqs[sel];
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (sel == SEL_W'(i)) begin
          iresps[i] = oresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: two instances (2 and 3 masters) share clock, reset and oresp.
// Expected grant order is queued when requests are raised and popped as each grant appears.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  cbus_resp_t oresp;

  cbus_req_t  ireq2 [2];
  cbus_resp_t iresp2[2];
  cbus_req_t  oreq2;
  cbus_req_t  ireq3 [3];
  cbus_resp_t iresp3[3];
  cbus_req_t  oreq3;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  bit use3 = 1'b0;
  bit rr;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut2 (
    .clk(clk), .reset(reset), .ireqs(ireq2), .iresps(iresp2), .oreq(oreq2), .oresp(oresp)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .ireqs(ireq3), .iresps(iresp3), .oreq(oreq3), .oresp(oresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic cbus_req_t mon_req();
    return use3 ? oreq3 : oreq2;
  endfunction

  function automatic cbus_resp_t resp_of(input int i);
    if (use3) return iresp3[i];
    return iresp2[i];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [7:0] len, input logic wr);
    cbus_req_t r;
    r          = '0;
    r.valid    = v;
    r.is_write = wr;
    r.size     = 3'd3;
    r.len      = len;
    r.addr     = addr_of(i);
    r.data     = wr ? {32'hDA7A_0000, 32'(i)} : 64'd0;
    r.strobe   = wr ? 8'hFF : 8'h00;
    if (use3) ireq3[i] = r;
    else      ireq2[i] = r;
  endtask

  task automatic set_valid(input int i, input logic v);
    if (use3) ireq3[i].valid = v;
    else      ireq2[i].valid = v;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) ireq2[i] = '0;
    for (int i = 0; i < 3; i++) ireq3[i] = '0;
  endtask

  // Wait (bounded) for a grant, match it against the scoreboard, run the burst, check the bubble
  task automatic serve(input int nbeats, input bit drop, output int granted);
    int waited = 0;
    int n = use3 ? 3 : 2;
    while (!mon_req().valid && waited < 8) begin
      tick();
      waited++;
    end
    check("grant_latency", 64'(waited), 64'd1);
    granted = 0;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 64'd1, 64'd0);
      return;
    end
    granted = exp_q.pop_front();
    check("grant_addr", 64'(mon_req().addr), 64'(addr_of(granted)));
    check("grant_len", 64'(mon_req().len), 64'(nbeats - 1));
    for (int b = 0; b < nbeats; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == nbeats - 1);
      oresp.data  = {$urandom, $urandom};
      #1;
      check("hold_addr", 64'(mon_req().addr), 64'(addr_of(granted)));
      check("resp_data", resp_of(granted).data, oresp.data);
      check("resp_last", 64'(resp_of(granted).last), 64'(oresp.last));
      for (int j = 0; j < n; j++) begin
        if (j != granted) check("idle_resp", 64'(|resp_of(j)), 64'd0);
      end
      tick();
    end
    oresp = '0;
    if (drop) set_valid(granted, 1'b0);
    #1;
    check("bubble", 64'(mon_req().valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    clear_reqs();
    oresp = '0;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_oreq2", 64'(|oreq2), 64'd0);
    check("rst_oreq3", 64'(|oreq3), 64'd0);
    for (int i = 0; i < 2; i++) check("rst_iresp2", 64'(|iresp2[i]), 64'd0);
    for (int i = 0; i < 3; i++) check("rst_iresp3", 64'(|iresp3[i]), 64'd0);
    check("rst_ptr2", 64'(dut2.ptr), 64'd0);
    reset = 1'b0;

    // Single requester, 4-beat read from master 1
    set_req(1, 1'b1, 8'd3, 1'b0);
    exp_q.push_back(1);
    serve(4, 1'b1, g);

    // Contention, both masters always valid, 2-beat bursts
    set_req(0, 1'b1, 8'd1, 1'b0);
    set_req(1, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back(rr ? (k % 2) : 0);
    for (int k = 0; k < 4; k++) serve(2, 1'b0, g);
    clear_reqs();
    tick();

    // Grant hold: master 1 arrives mid-burst of master 0
    set_req(0, 1'b1, 8'd3, 1'b0);
    tick();
    check("hold_grant_valid", 64'(oreq2.valid), 64'd1);
    check("hold_grant_addr", 64'(oreq2.addr), 64'(addr_of(0)));
    for (int b = 0; b < 4; b++) begin
      if (b == 2) set_req(1, 1'b1, 8'd0, 1'b0);
      oresp.ready = 1'b1;
      oresp.last  = (b == 3);
      oresp.data  = 64'(b);
      #1;
      check("hold_src", 64'(oreq2.addr), 64'(addr_of(0)));
      check("hold_m1_quiet", 64'(|iresp2[1]), 64'd0);
      tick();
    end
    oresp = '0;
    set_valid(0, 1'b0);
    #1;
    check("hold_bubble", 64'(oreq2.valid), 64'd0);
    tick();
    check("hold_m1_valid", 64'(oreq2.valid), 64'd1);
    check("hold_m1_addr", 64'(oreq2.addr), 64'(addr_of(1)));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    tick();
    oresp = '0;
    clear_reqs();
    tick();

    // Reset mid-burst, after one completed burst so ptr is non-zero in round-robin mode
    set_req(0, 1'b1, 8'd0, 1'b1);
    exp_q.push_back(0);
    serve(1, 1'b1, g);
    check("pre_rst_ptr", 64'(dut2.ptr), rr ? 64'd1 : 64'd0);
    set_req(1, 1'b1, 8'd3, 1'b0);
    tick();
    check("rst_burst_addr", 64'(oreq2.addr), 64'(addr_of(1)));
    oresp.ready = 1'b1;
    oresp.last  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(oreq2.valid), 64'd0);
    check("mid_rst_iresp0", 64'(|iresp2[0]), 64'd0);
    check("mid_rst_iresp1", 64'(|iresp2[1]), 64'd0);
    check("mid_rst_ptr", 64'(dut2.ptr), 64'd0);
    reset = 1'b0;
    oresp = '0;
    clear_reqs();
    tick();
    set_req(1, 1'b1, 8'd0, 1'b0);
    exp_q.push_back(1);
    serve(1, 1'b1, g);

    // Single-beat back-to-back writes from both masters
    set_req(0, 1'b1, 8'd0, 1'b1);
    set_req(1, 1'b1, 8'd0, 1'b1);
    for (int k = 0; k < 4; k++) exp_q.push_back(rr ? (k % 2) : 0);
    for (int k = 0; k < 4; k++) serve(1, 1'b0, g);
    clear_reqs();
    tick();

    // Three masters, pointer wrap
    use3 = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back(rr ? (k % 3) : 0);
    for (int k = 0; k < 4; k++) begin
      serve(2, 1'b0, g);
      check("wrap_ptr", 64'(dut3.ptr), rr ? 64'((g + 1) % 3) : 64'd0);
    end
    clear_reqs();
    tick();
    use3 = 1'b0;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
